// File: rtl/ext_alu_wb_sched_if.sv
// rtl/ext_alu_wb_sched_if.sv - ID, ext-ALU and RF write-port signals of the ext-ALU write-back scheduler
//
// slave modport  : scheduler side
// master modport : environment side (ID stage, ext ALU, normal write-back, RF)
// Signals: issue_vld/issue_dst, id_src1_vld/id_src1, id_src2_vld/id_src2, id_we/id_dst,
//          stall_ID, ext_start, ext_done/ext_result, pipe_we/pipe_addr/pipe_data,
//          rf_we/rf_w_addr/rf_w_data, busy, err
interface ext_alu_wb_sched_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 4
);
    logic              issue_vld;
    logic [REG_W-1:0]  issue_dst;
    logic              id_src1_vld;
    logic [REG_W-1:0]  id_src1;
    logic              id_src2_vld;
    logic [REG_W-1:0]  id_src2;
    logic              id_we;
    logic [REG_W-1:0]  id_dst;
    logic              stall_ID;
    logic              ext_start;
    logic              ext_done;
    logic [DATA_W-1:0] ext_result;
    logic              pipe_we;
    logic [REG_W-1:0]  pipe_addr;
    logic [DATA_W-1:0] pipe_data;
    logic              rf_we;
    logic [REG_W-1:0]  rf_w_addr;
    logic [DATA_W-1:0] rf_w_data;
    logic              busy;
    logic              err;

    modport slave (
        input  issue_vld, issue_dst, id_src1_vld, id_src1, id_src2_vld, id_src2,
               id_we, id_dst, ext_done, ext_result, pipe_we, pipe_addr, pipe_data,
        output stall_ID, ext_start, rf_we, rf_w_addr, rf_w_data, busy, err
    );

    modport master (
        output issue_vld, issue_dst, id_src1_vld, id_src1, id_src2_vld, id_src2,
               id_we, id_dst, ext_done, ext_result, pipe_we, pipe_addr, pipe_data,
        input  stall_ID, ext_start, rf_we, rf_w_addr, rf_w_data, busy, err
    );
endinterface

// File: rtl/ext_alu_wb_sched.sv
// rtl/ext_alu_wb_sched.sv - RF write-port scheduler and ID hazard stall for the in-order external ALU
//
// Ports: clk, rst_n (async, active-low), bus (ext_alu_wb_sched_if.slave).
// Tag FIFO holds destinations of ops waiting for ext_done; result FIFO holds finished
// {addr, data} waiting for an RF port cycle left idle by the normal write-back.
module ext_alu_wb_sched #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 4,
    parameter int DEPTH  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    ext_alu_wb_sched_if.slave  bus
);
    // Storage is at least two slots so the index is never zero bits wide; occupancy
    // is still limited to DEPTH by the capacity check.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SZ = 1 << AW;

    logic [REG_W-1:0]  t_mem  [SZ];
    logic [REG_W-1:0]  r_addr [SZ];
    logic [DATA_W-1:0] r_data [SZ];
    logic [AW:0]       t_wr, t_rd, r_wr, r_rd;
    logic [AW:0]       t_cnt, r_cnt;
    logic [AW+1:0]     n_out;

    logic              ext_start_q, err_q;
    logic              stall, issue_acc, done_ok, r_pop;

    assign t_cnt = t_wr - t_rd;
    assign r_cnt = r_wr - r_rd;
    assign n_out = {1'b0, t_cnt} + {1'b0, r_cnt};

    // Flattened view of every outstanding destination, oldest first per FIFO.
    logic [2*SZ-1:0]   ent_vld;
    logic [REG_W-1:0]  ent_addr [2*SZ];

    always_comb begin
        for (int k = 0; k < SZ; k++) begin
            ent_vld[k]       = (AW+1)'(k) < t_cnt;
            ent_addr[k]      = t_mem[t_rd[AW-1:0] + AW'(k)];
            ent_vld[SZ+k]    = (AW+1)'(k) < r_cnt;
            ent_addr[SZ+k]   = r_addr[r_rd[AW-1:0] + AW'(k)];
        end
    end

    // Entries leaving this cycle still match: costs at most one extra stall cycle
    // but keeps the compare off the pop/write-port logic.
    logic src1_hit, src2_hit, iss_hit, dst_hit;

    always_comb begin
        src1_hit = 1'b0;
        src2_hit = 1'b0;
        iss_hit  = 1'b0;
        dst_hit  = 1'b0;
        for (int k = 0; k < 2*SZ; k++) begin
            if (ent_vld[k]) begin
                if (ent_addr[k] == bus.id_src1)   src1_hit = 1'b1;
                if (ent_addr[k] == bus.id_src2)   src2_hit = 1'b1;
                if (ent_addr[k] == bus.issue_dst) iss_hit  = 1'b1;
                if (ent_addr[k] == bus.id_dst)    dst_hit  = 1'b1;
            end
        end
    end

    assign stall = (bus.issue_vld   && (n_out == (AW+2)'(DEPTH)))
                 || (bus.id_src1_vld && src1_hit)
                 || (bus.id_src2_vld && src2_hit)
                 || (bus.issue_vld   && iss_hit)
                 || (bus.id_we       && dst_hit);

    assign issue_acc = bus.issue_vld && !stall;
    assign done_ok   = bus.ext_done && (t_cnt != '0);
    assign r_pop     = !bus.pipe_we && (r_cnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_wr        <= '0;
            t_rd        <= '0;
            r_wr        <= '0;
            r_rd        <= '0;
            ext_start_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if (issue_acc) t_wr <= t_wr + 1'b1;
            if (done_ok) begin
                t_rd <= t_rd + 1'b1;
                r_wr <= r_wr + 1'b1;
            end
            if (r_pop) r_rd <= r_rd + 1'b1;
            // The op reaches EX the cycle after it leaves ID.
            ext_start_q <= issue_acc;
            if (bus.ext_done && (t_cnt == '0)) err_q <= 1'b1;
        end
    end

    // Payload storage needs no reset: pointers define what is valid.
    always_ff @(posedge clk) begin
        if (issue_acc) t_mem[t_wr[AW-1:0]] <= bus.issue_dst;
        if (done_ok) begin
            r_addr[r_wr[AW-1:0]] <= t_mem[t_rd[AW-1:0]];
            r_data[r_wr[AW-1:0]] <= bus.ext_result;
        end
    end

    // Normal write-back always owns the port; buffered results fill the gaps.
    always_comb begin
        bus.rf_we     = 1'b0;
        bus.rf_w_addr = '0;
        bus.rf_w_data = '0;
        if (bus.pipe_we) begin
            bus.rf_we     = 1'b1;
            bus.rf_w_addr = bus.pipe_addr;
            bus.rf_w_data = bus.pipe_data;
        end else if (r_cnt != '0) begin
            bus.rf_we     = 1'b1;
            bus.rf_w_addr = r_addr[r_rd[AW-1:0]];
            bus.rf_w_data = r_data[r_rd[AW-1:0]];
        end
    end

    assign bus.stall_ID  = stall;
    assign bus.ext_start = ext_start_q;
    assign bus.busy      = (n_out != '0);
    assign bus.err       = err_q;
endmodule

// File: doc/ext_alu_wb_sched.md
Name: ext_alu_wb_sched

Overview:
- Scheduler for the shared register-file write port and the multi-cycle, in-order external ALU.
- Accepts ext-ALU issues from ID and tracks their destination registers until write-back.
- Buffers ext-ALU results and merges them onto the RF write port in cycles the normal pipeline write-back leaves idle.
- Generates the ID stall for capacity, RAW and WAW hazards against outstanding ext-ALU ops.

Parameters:
DATA_W, 32, RF write data width
REG_W, 4, RF address width (16 registers)
DEPTH, 2, max outstanding ext-ALU ops (in flight plus completed-not-written), power of 2, 1..8

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
issue_vld  in  1  ID instruction is an ext-ALU op
issue_dst  in  REG_W  its destination register
id_src1_vld  in  1  ID instruction reads id_src1
id_src1  in  REG_W  source 1 address
id_src2_vld  in  1  ID instruction reads id_src2
id_src2  in  REG_W  source 2 address
id_we  in  1  ID instruction writes a register via the normal pipeline
id_dst  in  REG_W  that destination
stall_ID  out  1  hold ID, inject bubble (combinational)
ext_start  out  1  one-cycle start pulse to ext ALU
ext_done  in  1  ext ALU result valid (one cycle, in issue order)
ext_result  in  DATA_W  ext ALU result
pipe_we  in  1  normal write-back wants the RF port this cycle
pipe_addr  in  REG_W  normal write-back address
pipe_data  in  DATA_W  normal write-back data
rf_we  out  1  RF write enable
rf_w_addr  out  REG_W  RF write address
rf_w_data  out  DATA_W  RF write data
busy  out  1  any op outstanding
err  out  1  sticky protocol error

Behaviour:
- State:
  - Tag FIFO T: dst addresses of issued ops awaiting ext_done, depth DEPTH.
  - Result FIFO R: completed {addr, data}, depth DEPTH.
  - Outstanding count N = |T| + |R|, never exceeds DEPTH.
- Reset (async, rst_n=0):
  - T and R empty, N=0.
  - ext_start=0, err=0, busy=0.
  - rf_we follows pipe_we combinationally.
  - A reset during an operation discards everything outstanding.
- stall_ID is 1 when any of the following holds:
  - Capacity: issue_vld and N==DEPTH.
  - RAW: id_src1_vld or id_src2_vld and the corresponding address matches any valid entry in T or R.
  - WAW: issue_vld and issue_dst matches an outstanding entry, or id_we and id_dst matches an outstanding entry.
  - Conservative match: an entry being popped/written this cycle still counts, giving a one-cycle extra stall at most.
- Issue:
  - Accepted when issue_vld and !stall_ID.
  - Push issue_dst to T at the clock edge.
  - ext_start=1 on the following cycle only, because the op is then in EX.
- Completion:
  - On ext_done, pop T head and push {head addr, ext_result} to R in the same edge.
  - ext_done with T empty: ignore the data and set err=1 until reset.
- Write-port arbitration (combinational outputs):
  - pipe_we=1: rf_we=1, rf_w_addr=pipe_addr, rf_w_data=pipe_data. R is not popped.
  - pipe_we=0 and R non-empty: rf_we=1, drive R head; pop R at the edge.
  - Otherwise rf_we=0; addr and data are don't-care and are driven 0.
- Forward progress: stalling ID creates bubbles that reach WB, so R always drains. No starvation counter is required.
- Simultaneous events: issue push, ext_done transfer and R pop may all occur in the same cycle. Compute N as N + push − pop(R).
- busy = (N != 0).
- Widths: FIFO pointers wrap modulo DEPTH, with an extra bit for full/empty.

Test Plan:
- Reset mid-operation: issue R3, assert rst_n=0 before ext_done, then release reset and pulse ext_done with 0x55 -> busy=0, no write to R3, err=1 after that stray ext_done.
- Basic issue: issue_dst=5 at cycle 0, ext_done with 0xDEADBEEF at cycle 4, pipe_we=0 -> ext_start=1 at cycle 1, rf_we=1 with addr 5 / data 0xDEADBEEF at cycle 5, busy=0 at cycle 6.
- Port conflict: R holds {7, 0x12345678} while pipe_we=1 for 3 cycles with addr 2 / data 0x1 -> pipe writes pass through for 3 cycles, R3-entry writes addr 7 on the 4th cycle.
- RAW stall: outstanding dst 9, ID presents id_src2_vld=1 with id_src2=9 -> stall_ID=1 until the cycle after R9 is written. id_src2=8 gives no stall.
- Capacity: DEPTH=2, issue dst 1, then dst 2, then a third issue dst 3 -> the third is stalled until one result is written, then accepted; ext_start is pulsed exactly 3 times.
- Error: ext_done=1 with T empty -> err=1 and it stays 1. No rf_we results from that ext_done.
